// File: rtl/wwfa_crossbar_scheduler_if.sv
// Handshake bundle between the input-port queue heads,
// the crossbar datapath and the wavefront connection scheduler.
interface wwfa_crossbar_scheduler_if;
    logic [3:0] req;
    logic [7:0] addr;
    logic [3:0] xfer;
    logic [3:0] last;
    logic [3:0] out_blocked;
    logic [3:0] grant;
    logic [7:0] conn_dst;
    logic [7:0] out_sel;
    logic [3:0] out_busy;
    logic [1:0] prio_diag;
    logic [3:0] timeout_evt;

    modport master (
        output req,
        output addr,
        output xfer,
        output last,
        output out_blocked,
        input  grant,
        input  conn_dst,
        input  out_sel,
        input  out_busy,
        input  prio_diag,
        input  timeout_evt
    );

    modport slave (
        input  req,
        input  addr,
        input  xfer,
        input  last,
        input  out_blocked,
        output grant,
        output conn_dst,
        output out_sel,
        output out_busy,
        output prio_diag,
        output timeout_evt
    );
endinterface

// File: rtl/wwfa_crossbar_scheduler.sv
// 4x4 crossbar connection scheduler: registered wrapped-wavefront
// arbiter with rotating priority diagonal, EOP and idle-timeout release.
module wwfa_crossbar_scheduler #(
    parameter int N_PORTS = 4,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic reset,
    wwfa_crossbar_scheduler_if.slave bus
);

    if (N_PORTS != 4 || ADDR_W != 2) begin : g_bad_size
        $error("wwfa_crossbar_scheduler supports only a 4x4 crossbar");
    end

    if (TIMEOUT < 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wwfa_crossbar_scheduler TIMEOUT must be 0..255");
    end

    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);
    localparam bit         TO_EN  = (TIMEOUT != 0);

    logic [3:0]      grant_q;
    logic [3:0][1:0] dst_q;
    logic [3:0][1:0] sel_q;
    logic [3:0]      busy_q;
    logic [1:0]      prio_q;
    logic [3:0]      tevt_q;
    logic [3:0][7:0] idle_q;

    logic [3:0]      eop;
    logic [3:0]      to_hit;
    logic [3:0]      rel;
    logic [3:0]      rel_col;
    logic [3:0]      win_row;
    logic [3:0]      win_col;
    logic [3:0][1:0] win_dst;
    logic [3:0][1:0] win_src;

    // Column of cell in row i on the k-th diagonal of the wave.
    function automatic logic [1:0] cell_col(
        input logic [1:0] p,
        input int         k,
        input int         i
    );
        return 2'(int'(p) + k - i);
    endfunction

    // Release sources: qualified end-of-packet or expired idle counter.
    always_comb begin
        eop     = '0;
        to_hit  = '0;
        rel     = '0;
        rel_col = '0;
        for (int i = 0; i < 4; i++) begin
            eop[i]    = grant_q[i] & bus.xfer[i] & bus.last[i];
            to_hit[i] = TO_EN && grant_q[i] && (idle_q[i] == TO_VAL);
            rel[i]    = eop[i] | to_hit[i];
            if (rel[i]) begin
                rel_col[dst_q[i]] = 1'b1;
            end
        end
    end

    // Wavefront sweep: diagonals P..P+3, earlier winners mask later cells.
    always_comb begin
        win_row = '0;
        win_col = '0;
        win_dst = '0;
        win_src = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req[i]
                    && bus.addr[2*i +: 2] == cell_col(prio_q, k, i)
                    && !grant_q[i]
                    && !win_row[i]
                    && !busy_q[cell_col(prio_q, k, i)]
                    && !bus.out_blocked[cell_col(prio_q, k, i)]
                    && !win_col[cell_col(prio_q, k, i)]) begin
                    win_row[i] = 1'b1;
                    win_col[cell_col(prio_q, k, i)] = 1'b1;
                    win_dst[i] = cell_col(prio_q, k, i);
                    win_src[cell_col(prio_q, k, i)] = 2'(i);
                end
            end
        end
    end

    // Row state: set on a win, cleared on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            dst_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rel[i]) begin
                    grant_q[i] <= 1'b0;
                end else if (win_row[i]) begin
                    grant_q[i] <= 1'b1;
                    dst_q[i]   <= win_dst[i];
                end
            end
        end
    end

    // Column state: mirrors row state so busy/select track held links.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            sel_q  <= '0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (win_col[j]) begin
                    busy_q[j] <= 1'b1;
                    sel_q[j]  <= win_src[j];
                end else if (rel_col[j]) begin
                    busy_q[j] <= 1'b0;
                end
            end
        end
    end

    // Priority rotates only when a new grant is issued; timeout pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= '0;
            tevt_q <= '0;
        end else begin
            if (|win_row) begin
                prio_q <= prio_q + 2'd1;
            end
            tevt_q <= to_hit & ~eop;
        end
    end

    // Saturating idle counters for held connections.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!grant_q[i] || rel[i] || bus.xfer[i]) begin
                    idle_q[i] <= '0;
                end else if (idle_q[i] != 8'hFF) begin
                    idle_q[i] <= idle_q[i] + 8'd1;
                end
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.conn_dst    = dst_q;
    assign bus.out_sel     = sel_q;
    assign bus.out_busy    = busy_q;
    assign bus.prio_diag   = prio_q;
    assign bus.timeout_evt = tevt_q;

endmodule

// File: tb/tb_wwfa_crossbar_scheduler.sv
// Directed bench for the wavefront crossbar scheduler
// (instance built with TIMEOUT=4).
module tb_wwfa_crossbar_scheduler;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wwfa_crossbar_scheduler_if bus();

    wwfa_crossbar_scheduler #(
        .N_PORTS(4),
        .ADDR_W (2),
        .TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req         = '0;
        bus.addr        = '0;
        bus.xfer        = '0;
        bus.last        = '0;
        bus.out_blocked = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grant got %b want 0000", bus.grant);
        end
        checks++;
        if (bus.out_busy !== 4'b0000) begin
            errors++;
            $display("FAIL reset_busy got %b want 0000", bus.out_busy);
        end
        checks++;
        if (bus.prio_diag !== 2'd0 || bus.timeout_evt !== 4'b0) begin
            errors++;
            $display("FAIL reset_prio_evt got %0d/%b want 0/0000",
                     bus.prio_diag, bus.timeout_evt);
        end
    endtask

    task automatic test_same_dest();
        bus.req  = 4'b1111;
        bus.addr = 8'b10101010;
        tick();
        checks++;
        if (bus.grant !== 4'b0100) begin
            errors++;
            $display("FAIL same_grant got %b want 0100", bus.grant);
        end
        checks++;
        if (bus.out_busy !== 4'b0100 || bus.out_sel[5:4] !== 2'd2) begin
            errors++;
            $display("FAIL same_busy_sel got %b/%0d want 0100/2",
                     bus.out_busy, bus.out_sel[5:4]);
        end
        checks++;
        if (bus.prio_diag !== 2'd1 || bus.conn_dst[5:4] !== 2'd2) begin
            errors++;
            $display("FAIL same_prio_dst got %0d/%0d want 1/2",
                     bus.prio_diag, bus.conn_dst[5:4]);
        end
    endtask

    task automatic test_eop_bubble();
        bus.req  = 4'b1011;
        bus.xfer = 4'b0100;
        bus.last = 4'b0100;
        tick();
        bus.xfer = '0;
        bus.last = '0;
        checks++;
        if (bus.grant !== 4'b0000 || bus.out_busy !== 4'b0000) begin
            errors++;
            $display("FAIL eop_bubble got %b/%b want 0000/0000",
                     bus.grant, bus.out_busy);
        end
        checks++;
        if (bus.prio_diag !== 2'd1) begin
            errors++;
            $display("FAIL eop_bubble_prio got %0d want 1", bus.prio_diag);
        end
        tick();
        checks++;
        if (bus.grant !== 4'b1000 || bus.out_busy !== 4'b0100) begin
            errors++;
            $display("FAIL eop_regrant got %b/%b want 1000/0100",
                     bus.grant, bus.out_busy);
        end
        checks++;
        if (bus.out_sel[5:4] !== 2'd3 || bus.prio_diag !== 2'd2) begin
            errors++;
            $display("FAIL eop_regrant_sel got %0d/%0d want 3/2",
                     bus.out_sel[5:4], bus.prio_diag);
        end
    endtask

    task automatic test_full_match();
        do_reset();
        bus.req  = 4'b1111;
        bus.addr = 8'b00_11_10_01;
        tick();
        checks++;
        if (bus.grant !== 4'b1111 || bus.out_busy !== 4'b1111) begin
            errors++;
            $display("FAIL full_grant got %b/%b want 1111/1111",
                     bus.grant, bus.out_busy);
        end
        checks++;
        if (bus.out_sel !== 8'b10_01_00_11 || bus.prio_diag !== 2'd1) begin
            errors++;
            $display("FAIL full_sel got %b/%0d want 10010011/1",
                     bus.out_sel, bus.prio_diag);
        end
        checks++;
        if (bus.conn_dst !== 8'b00_11_10_01) begin
            errors++;
            $display("FAIL full_dst got %b want 00111001", bus.conn_dst);
        end
    endtask

    task automatic test_async_reset();
        bus.req = '0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 4'b0 || bus.out_busy !== 4'b0
            || bus.conn_dst !== 8'b0 || bus.out_sel !== 8'b0) begin
            errors++;
            $display("FAIL async_reset got %b/%b/%b/%b want zeros",
                     bus.grant, bus.out_busy, bus.conn_dst, bus.out_sel);
        end
        checks++;
        if (bus.prio_diag !== 2'd0 || bus.timeout_evt !== 4'b0) begin
            errors++;
            $display("FAIL async_reset_prio got %0d/%b want 0/0000",
                     bus.prio_diag, bus.timeout_evt);
        end
        tick();
        reset    = 1'b0;
        bus.req  = 4'b1111;
        bus.addr = 8'b10101010;
        tick();
        checks++;
        if (bus.grant !== 4'b0100 || bus.prio_diag !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_grant got %b/%0d want 0100/1",
                     bus.grant, bus.prio_diag);
        end
    endtask

    task automatic test_blocked();
        do_reset();
        bus.out_blocked = 4'b0010;
        bus.req         = 4'b0001;
        bus.addr        = 8'b00000001;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus.grant !== 4'b0000 || bus.prio_diag !== 2'd0) begin
                errors++;
                $display("FAIL blocked_c%0d got %b/%0d want 0000/0",
                         c, bus.grant, bus.prio_diag);
            end
        end
        bus.out_blocked = 4'b0000;
        tick();
        checks++;
        if (bus.grant !== 4'b0001 || bus.out_busy !== 4'b0010) begin
            errors++;
            $display("FAIL unblocked got %b/%b want 0001/0010",
                     bus.grant, bus.out_busy);
        end
        checks++;
        if (bus.out_sel[3:2] !== 2'd0 || bus.prio_diag !== 2'd1) begin
            errors++;
            $display("FAIL unblocked_sel got %0d/%0d want 0/1",
                     bus.out_sel[3:2], bus.prio_diag);
        end
        bus.out_blocked = 4'b0010;
        tick();
        checks++;
        if (bus.grant !== 4'b0001 || bus.out_busy !== 4'b0010) begin
            errors++;
            $display("FAIL block_held got %b/%b want 0001/0010",
                     bus.grant, bus.out_busy);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req  = 4'b0001;
        bus.addr = 8'b00000000;
        tick();
        bus.req = '0;
        checks++;
        if (bus.grant !== 4'b0001) begin
            errors++;
            $display("FAIL to_grant got %b want 0001", bus.grant);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (bus.grant !== 4'b0001 || bus.timeout_evt !== 4'b0) begin
                errors++;
                $display("FAIL to_hold_c%0d got %b/%b want 0001/0000",
                         c, bus.grant, bus.timeout_evt);
            end
        end
        tick();
        checks++;
        if (bus.grant !== 4'b0 || bus.out_busy !== 4'b0
            || bus.timeout_evt !== 4'b0001) begin
            errors++;
            $display("FAIL to_release got %b/%b/%b want 0000/0000/0001",
                     bus.grant, bus.out_busy, bus.timeout_evt);
        end
        tick();
        checks++;
        if (bus.timeout_evt !== 4'b0) begin
            errors++;
            $display("FAIL to_pulse got %b want 0000", bus.timeout_evt);
        end
    endtask

    task automatic test_timeout_with_last();
        bus.req  = 4'b0001;
        bus.addr = 8'b00000000;
        tick();
        bus.req = '0;
        checks++;
        if (bus.grant !== 4'b0001) begin
            errors++;
            $display("FAIL tl_grant got %b want 0001", bus.grant);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
        end
        bus.xfer = 4'b0001;
        bus.last = 4'b0001;
        tick();
        bus.xfer = '0;
        bus.last = '0;
        checks++;
        if (bus.grant !== 4'b0 || bus.out_busy !== 4'b0
            || bus.timeout_evt !== 4'b0) begin
            errors++;
            $display("FAIL tl_release got %b/%b/%b want 0000/0000/0000",
                     bus.grant, bus.out_busy, bus.timeout_evt);
        end
        tick();
        checks++;
        if (bus.timeout_evt !== 4'b0) begin
            errors++;
            $display("FAIL tl_pulse got %b want 0000", bus.timeout_evt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_same_dest();
        test_eop_bubble();
        test_full_match();
        test_async_reset();
        test_blocked();
        test_timeout();
        test_timeout_with_last();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
